// File: rtl/weapon_bank.sv
// Multi-channel ammunition and fire controller. Each channel has a saturating ammo
// count and its own IDLE/COOL/RELOAD FSM that handles mode gating, cooldown and timed reload.
module weapon_bank #(
  parameter int          CH         = 4,
  parameter int          AW         = 9,
  parameter int          MAX_AMMO   = 500,
  parameter int          COOL_CYC   = 3,
  parameter int          RELOAD_CYC = 4,
  parameter logic [3:0]  ATTACK     = 4'b0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         mode_sel,
  input  logic [CH-1:0]      fire,
  input  logic [CH-1:0]      load,
  input  logic [CH*AW-1:0]   load_val,
  input  logic [CH*AW-1:0]   rate,
  output logic [CH*AW-1:0]   ammo,
  output logic [CH-1:0]      shot,
  output logic [CH-1:0]      error,
  output logic [CH-1:0]      empty,
  output logic [CH-1:0]      busy
);

  localparam int TMAX = (COOL_CYC > RELOAD_CYC) ? COOL_CYC : RELOAD_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  // Timers are loaded with N-1 so a phase lasts exactly N cycles before leaving.
  localparam logic [TW-1:0] COOL_LOAD   = TW'(COOL_CYC - 1);
  localparam logic [TW-1:0] RELOAD_LOAD = TW'(RELOAD_CYC - 1);
  localparam logic [AW-1:0] MAX_VAL     = AW'(MAX_AMMO);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COOL   = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t          st, st_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic [AW-1:0]   cnt, cnt_nxt;
    logic [AW-1:0]   lat, lat_nxt;
    logic            shot_q, shot_nxt;
    logic            err_q, err_nxt;
    logic            busy_q, empty_q;
    logic [AW-1:0]   lv, rt, cost, clamp;
    logic            legal;

    assign lv    = load_val[i*AW +: AW];
    assign rt    = rate[i*AW +: AW];
    assign cost  = (rt == '0) ? AW'(1) : rt;
    assign clamp = (lv > MAX_VAL) ? MAX_VAL : lv;
    assign legal = (mode_sel == ATTACK) && (cnt != '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
        st  <= ST_IDLE;
        tmr <= '0;
      end else begin
        st  <= st_nxt;
        tmr <= tmr_nxt;
      end
    end

    // Next-state logic.
    always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      st_nxt  = st;
      tmr_nxt = tmr;
      unique case (st)
        ST_IDLE: begin
          if (load[i]) begin
            st_nxt  = ST_RELOAD;
            tmr_nxt = RELOAD_LOAD;
          end else if (fire[i] && legal) begin
            st_nxt  = ST_COOL;
            tmr_nxt = COOL_LOAD;
          end
        end
        ST_COOL: begin
          if (load[i]) begin
            st_nxt  = ST_RELOAD;
            tmr_nxt = RELOAD_LOAD;
          end else if (tmr == '0) begin
            st_nxt  = ST_IDLE;
          end else begin
            tmr_nxt = tmr - TW'(1);
          end
        end
        ST_RELOAD: begin
          if (tmr == '0) st_nxt  = ST_IDLE;
          else           tmr_nxt = tmr - TW'(1);
        end
        default: begin
          st_nxt  = ST_IDLE;
          tmr_nxt = '0;
        end
      endcase
    end

    // Output / datapath logic; results are registered below.
    always_comb begin
      cnt_nxt  = cnt;
      lat_nxt  = lat;
      shot_nxt = 1'b0;
      err_nxt  = 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (load[i]) begin
            lat_nxt = clamp;
            err_nxt = fire[i];
          end else if (fire[i]) begin
            if (legal) begin
              shot_nxt = 1'b1;
              cnt_nxt  = (cnt >= cost) ? cnt - cost : '0;
            end else begin
              err_nxt  = 1'b1;
            end
          end
        end
        ST_COOL: begin
          if (load[i]) lat_nxt = clamp;
        end
        ST_RELOAD: begin
          err_nxt = fire[i];
          if (tmr == '0) cnt_nxt = lat;
        end
        default: ;
      endcase
    end

    // A reset discards any pending reload value along with the count.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt     <= '0;
        lat     <= '0;
        shot_q  <= 1'b0;
        err_q   <= 1'b0;
        busy_q  <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        cnt     <= cnt_nxt;
        lat     <= lat_nxt;
        shot_q  <= shot_nxt;
        err_q   <= err_nxt;
        busy_q  <= (st_nxt != ST_IDLE);
        empty_q <= (cnt_nxt == '0);
      end
    end

    assign ammo[i*AW +: AW] = cnt;
    assign shot[i]          = shot_q;
    assign error[i]         = err_q;
    assign busy[i]          = busy_q;
    assign empty[i]         = empty_q;
  end

endmodule

// File: tb/tb_weapon_bank.sv
// Self-checking bench for weapon_bank: directed scenarios plus randomized traffic,
// all compared against a cycle-indexed behavioural model of each channel.
module tb_weapon_bank;
  localparam int         CH         = 4;
  localparam int         AW         = 9;
  localparam int         MAX_AMMO   = 500;
  localparam int         COOL_CYC   = 3;
  localparam int         RELOAD_CYC = 4;
  localparam logic [3:0] ATTACK     = 4'b0010;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        mode_sel;
  logic [CH-1:0]     fire, load;
  logic [CH*AW-1:0]  load_val, rate;
  logic [CH*AW-1:0]  ammo;
  logic [CH-1:0]     shot, error, empty, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  weapon_bank #(
    .CH(CH), .AW(AW), .MAX_AMMO(MAX_AMMO), .COOL_CYC(COOL_CYC),
    .RELOAD_CYC(RELOAD_CYC), .ATTACK(ATTACK)
  ) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .fire(fire), .load(load),
    .load_val(load_val), .rate(rate), .ammo(ammo), .shot(shot),
    .error(error), .empty(empty), .busy(busy)
  );

  // Model: per channel, the count plus absolute edge numbers at which
  // the cooldown ends and the pending reload lands.
  longint cyc = 0;
  int     m_ammo[CH];
  int     m_lat[CH];
  bit     m_rel[CH];
  longint m_land[CH];
  longint m_cool_last[CH];
  logic [CH*AW-1:0] e_ammo;
  logic [CH-1:0]    e_shot, e_err, e_busy, e_empty;

  function automatic void model_vectors();
    for (int c = 0; c < CH; c++) begin
      e_ammo[c*AW +: AW] = AW'(m_ammo[c]);
      e_empty[c]         = (m_ammo[c] == 0);
      e_busy[c]          = m_rel[c] || (cyc - 1 < m_cool_last[c]);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ammo[c] = 0; m_lat[c] = 0; m_rel[c] = 0;
      m_land[c] = 0; m_cool_last[c] = -100;
    end
    e_shot = '0;
    e_err  = '0;
    model_vectors();
    for (int c = 0; c < CH; c++) e_busy[c] = 1'b0;
  endfunction

  function automatic void model_edge();
    int lv, r;
    if (!rst) begin
      model_reset();
      cyc++;
      return;
    end
    for (int c = 0; c < CH; c++) begin
      lv = int'(load_val[c*AW +: AW]);
      if (lv > MAX_AMMO) lv = MAX_AMMO;
      r = int'(rate[c*AW +: AW]);
      if (r == 0) r = 1;
      e_shot[c] = 1'b0;
      e_err[c]  = 1'b0;
      if (m_rel[c]) begin
        e_err[c] = fire[c];
        if (cyc == m_land[c]) begin
          m_ammo[c] = m_lat[c];
          m_rel[c]  = 0;
        end
      end else if (cyc <= m_cool_last[c]) begin
        if (load[c]) begin
          m_rel[c] = 1; m_land[c] = cyc + RELOAD_CYC; m_lat[c] = lv;
          m_cool_last[c] = -100;
        end
      end else if (load[c]) begin
        m_rel[c] = 1; m_land[c] = cyc + RELOAD_CYC; m_lat[c] = lv;
        e_err[c] = fire[c];
      end else if (fire[c]) begin
        if (mode_sel != ATTACK || m_ammo[c] == 0) begin
          e_err[c] = 1'b1;
        end else begin
          e_shot[c]      = 1'b1;
          m_ammo[c]      = (m_ammo[c] > r) ? m_ammo[c] - r : 0;
          m_cool_last[c] = cyc + COOL_CYC;
        end
      end
    end
    cyc++;
    model_vectors();
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic void set_lv(int c, int v);
    load_val[c*AW +: AW] = AW'(v);
  endfunction

  function automatic void set_rate(int c, int v);
    rate[c*AW +: AW] = AW'(v);
  endfunction

  task automatic test_reset();
    checks++;
    if (ammo !== '0 || empty !== '1 || busy !== '0 || shot !== '0 || error !== '0) begin
      failures++;
      $display("FAIL reset_state ammo=%h empty=%b busy=%b shot=%b error=%b required ammo=0 empty=1111 busy=0 shot=0 error=0",
               ammo, empty, busy, shot, error);
    end
    rst = 1'b1;
    set_lv(0, 500); load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ammo !== '0 || busy !== '0 || empty !== '1) begin
      failures++;
      $display("FAIL reset_mid_reload ammo=%h busy=%b empty=%b required 0/0000/1111", ammo, busy, empty);
    end
    #2 rst = 1'b1;
    repeat (6) tick();
    checks++;
    if (ammo[0 +: AW] !== '0 || busy[0] !== 1'b0 || empty[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_discard ch0 ammo=%0d busy=%b empty=%b required 0/0/1", ammo[0 +: AW], busy[0], empty[0]);
    end
  endtask

  task automatic test_load_fire();
    int nshots = 0;
    int nerr   = 0;
    mode_sel = ATTACK;
    set_rate(0, 5);
    set_lv(0, 500); load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    repeat (RELOAD_CYC) tick();
    checks++;
    if (ammo[0 +: AW] !== 9'd500) begin
      failures++;
      $display("FAIL load_500 ammo=%0d required 500", ammo[0 +: AW]);
    end
    fire[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      nshots += shot[0];
      nerr   += error[0];
      checks++;
      if ({ammo, shot, error, busy, empty} !== {e_ammo, e_shot, e_err, e_busy, e_empty}) begin
        failures++;
        $display("FAIL held_fire k=%0d ammo=%h shot=%b err=%b busy=%b empty=%b required ammo=%h shot=%b err=%b busy=%b empty=%b",
                 k, ammo, shot, error, busy, empty, e_ammo, e_shot, e_err, e_busy, e_empty);
      end
    end
    fire[0] = 1'b0;
    checks++;
    if (nshots != 5 || nerr != 0 || ammo[0 +: AW] !== 9'd475) begin
      failures++;
      $display("FAIL held_fire_total shots=%0d errors=%0d ammo=%0d required 5/0/475", nshots, nerr, ammo[0 +: AW]);
    end
  endtask

  task automatic test_saturation();
    set_lv(0, 3); load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    repeat (RELOAD_CYC) tick();
    fire[0] = 1'b1;
    tick();
    fire[0] = 1'b0;
    checks++;
    if (shot[0] !== 1'b1 || ammo[0 +: AW] !== '0 || empty[0] !== 1'b1 || error[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_shot shot=%b ammo=%0d empty=%b err=%b required 1/0/1/0", shot[0], ammo[0 +: AW], empty[0], error[0]);
    end
    repeat (COOL_CYC) tick();
    fire[0] = 1'b1;
    tick();
    fire[0] = 1'b0;
    checks++;
    if (error[0] !== 1'b1 || shot[0] !== 1'b0 || ammo[0 +: AW] !== '0) begin
      failures++;
      $display("FAIL empty_fire err=%b shot=%b ammo=%0d required 1/0/0", error[0], shot[0], ammo[0 +: AW]);
    end
  endtask

  task automatic test_gating();
    set_lv(1, 100); set_rate(1, 9); load[1] = 1'b1;
    tick();
    load[1] = 1'b0;
    repeat (RELOAD_CYC) tick();
    mode_sel = 4'b0001;
    fire[1] = 1'b1;
    tick();
    fire[1] = 1'b0;
    checks++;
    if (error[1] !== 1'b1 || shot[1] !== 1'b0 || ammo[AW +: AW] !== 9'd100) begin
      failures++;
      $display("FAIL mode_gate err=%b shot=%b ammo=%0d required 1/0/100", error[1], shot[1], ammo[AW +: AW]);
    end
    tick();
    checks++;
    if (error[1] !== 1'b0) begin
      failures++;
      $display("FAIL gate_pulse err=%b required 0", error[1]);
    end
  endtask

  task automatic test_priority_clamp();
    set_lv(0, 511);
    fire[0] = 1'b1; load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    checks++;
    if (error[0] !== 1'b1 || shot[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL load_prio err=%b shot=%b busy=%b required 1/0/1", error[0], shot[0], busy[0]);
    end
    for (int k = 0; k < RELOAD_CYC; k++) begin
      tick();
      checks++;
      if (error[0] !== 1'b1) begin
        failures++;
        $display("FAIL reload_fire_err k=%0d err=%b required 1", k, error[0]);
      end
    end
    fire[0] = 1'b0;
    checks++;
    if (ammo[0 +: AW] !== 9'd500 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL clamp ammo=%0d busy=%b required 500/0", ammo[0 +: AW], busy[0]);
    end
    tick();
  endtask

  task automatic test_independence();
    mode_sel = ATTACK;
    set_rate(0, 5); set_rate(2, 0); set_rate(3, 7);
    set_lv(3, 200); load[3] = 1'b1;
    tick();
    load[3] = 1'b0;
    repeat (RELOAD_CYC) tick();
    fire[3] = 1'b1;
    tick();
    fire[0] = 1'b1; load[2] = 1'b1; set_lv(2, 77);
    tick();
    load[2] = 1'b0;
    checks++;
    if (shot !== 4'b0001 || error !== 4'b0000 || busy !== 4'b1101 ||
        ammo[0 +: AW] !== 9'd495 || ammo[3*AW +: AW] !== 9'd193) begin
      failures++;
      $display("FAIL indep_mix shot=%b err=%b busy=%b ammo0=%0d ammo3=%0d required 0001/0000/1101/495/193",
               shot, error, busy, ammo[0 +: AW], ammo[3*AW +: AW]);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({ammo, shot, error, busy, empty} !== {e_ammo, e_shot, e_err, e_busy, e_empty}) begin
        failures++;
        $display("FAIL indep k=%0d ammo=%h shot=%b err=%b busy=%b empty=%b required ammo=%h shot=%b err=%b busy=%b empty=%b",
                 k, ammo, shot, error, busy, empty, e_ammo, e_shot, e_err, e_busy, e_empty);
      end
    end
    fire = '0;
    checks++;
    if (ammo[2*AW +: AW] !== 9'd77) begin
      failures++;
      $display("FAIL indep_reload ammo2=%0d required 77", ammo[2*AW +: AW]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      mode_sel = ($urandom_range(0, 3) != 0) ? ATTACK : 4'($urandom_range(0, 15));
      for (int c = 0; c < CH; c++) begin
        fire[c] = ($urandom_range(0, 1) == 1);
        load[c] = ($urandom_range(0, 11) == 0);
        set_lv(c, $urandom_range(0, 511));
        set_rate(c, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 120));
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ammo, shot, error, busy, empty} !== {e_ammo, e_shot, e_err, e_busy, e_empty}) begin
          failures++;
          $display("FAIL rand_reset k=%0d ammo=%h busy=%b empty=%b required ammo=%h busy=%b empty=%b",
                   k, ammo, busy, empty, e_ammo, e_busy, e_empty);
        end
        #1 rst = 1'b1;
      end
      tick();
      checks++;
      if ({ammo, shot, error, busy, empty} !== {e_ammo, e_shot, e_err, e_busy, e_empty}) begin
        failures++;
        $display("FAIL random k=%0d ammo=%h shot=%b err=%b busy=%b empty=%b required ammo=%h shot=%b err=%b busy=%b empty=%b",
                 k, ammo, shot, error, busy, empty, e_ammo, e_shot, e_err, e_busy, e_empty);
      end
    end
    fire = '0;
    load = '0;
  endtask

  initial begin
    rst      = 1'b0;
    mode_sel = 4'b0000;
    fire     = '0;
    load     = '0;
    load_val = '0;
    rate     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_fire();
    test_saturation();
    test_gating();
    test_priority_clamp();
    test_independence();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
